// File: rtl/seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module  : seq_multiplier
// Brief   : Shift-and-add sequential multiplier, start/done handshake.
// Revision: 1.0 - initial release
// ============================================================================
module seq_multiplier #(
    parameter int WIDTH  = 4,
    parameter bit SIGNED = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [CW-1:0]    count_q, count_d;
    logic             neg_q, neg_d;
    logic [PW-1:0]    product_q, product_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             neg_in;

    // The most negative operand negates to itself, which is its exact magnitude as unsigned.
    generate
        if (SIGNED) begin : g_signed
            assign a_mag  = a[WIDTH-1] ? (-a) : a;
            assign b_mag  = b[WIDTH-1] ? (-b) : b;
            assign neg_in = a[WIDTH-1] ^ b[WIDTH-1];
        end else begin : g_unsigned
            assign a_mag  = a;
            assign b_mag  = b;
            assign neg_in = 1'b0;
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        count_d   = count_q;
        neg_d     = neg_q;
        product_d = product_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = RUN;
                    busy_d   = 1'b1;
                    mcand_d  = {{WIDTH{1'b0}}, a_mag};
                    mplier_d = b_mag;
                    acc_d    = '0;
                    count_d  = CW'(WIDTH);
                    neg_d    = neg_in;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                busy_d = 1'b1;
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    state_d   = DONE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    product_d = neg_q ? (-acc_d) : acc_d;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            count_q   <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            neg_q     <= neg_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module  : tb_seq_multiplier
// Brief   : Self-checking bench for seq_multiplier in three configurations.
// Revision: 1.0 - initial release
// ============================================================================
module tb_seq_multiplier;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i [3];
    logic [15:0] a_in [3];
    logic [15:0] b_in [3];
    logic        busy_o [3];
    logic        done_o [3];
    logic [31:0] prod_o [3];
    logic [3:0]  p0;
    logic [7:0]  p1;
    logic [7:0]  p2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // cfg 0: WIDTH=2 unsigned, cfg 1: WIDTH=4 unsigned, cfg 2: WIDTH=4 signed
    seq_multiplier #(.WIDTH(2), .SIGNED(1'b0)) u_w2u (
        .clk(clk), .rst_n(rst_n), .start(start_i[0]), .a(a_in[0][1:0]), .b(b_in[0][1:0]),
        .busy(busy_o[0]), .done(done_o[0]), .product(p0));
    seq_multiplier #(.WIDTH(4), .SIGNED(1'b0)) u_w4u (
        .clk(clk), .rst_n(rst_n), .start(start_i[1]), .a(a_in[1][3:0]), .b(b_in[1][3:0]),
        .busy(busy_o[1]), .done(done_o[1]), .product(p1));
    seq_multiplier #(.WIDTH(4), .SIGNED(1'b1)) u_w4s (
        .clk(clk), .rst_n(rst_n), .start(start_i[2]), .a(a_in[2][3:0]), .b(b_in[2][3:0]),
        .busy(busy_o[2]), .done(done_o[2]), .product(p2));

    assign prod_o[0] = {28'b0, p0};
    assign prod_o[1] = {24'b0, p1};
    assign prod_o[2] = {24'b0, p2};

    function automatic int cfg_w(input int c);
        return (c == 0) ? 2 : 4;
    endfunction

    // Reference: interpret operands as integers, multiply, keep the low 2*W bits.
    function automatic logic [31:0] model(input int c, input logic [15:0] av, input logic [15:0] bv);
        longint w, ai, bi, r;
        w  = cfg_w(c);
        ai = longint'(av) & ((64'sd1 <<< w) - 1);
        bi = longint'(bv) & ((64'sd1 <<< w) - 1);
        if (c == 2) begin
            if (ai >= (64'sd1 <<< (w - 1))) ai = ai - (64'sd1 <<< w);
            if (bi >= (64'sd1 <<< (w - 1))) bi = bi - (64'sd1 <<< w);
        end
        r = (ai * bi) & ((64'sd1 <<< (2 * w)) - 1);
        return r[31:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Starts one operation from an idle DUT and checks the handshake timing.
    task automatic run_op(input int c, input logic [15:0] av, input logic [15:0] bv,
                          output logic [31:0] p);
        int k;
        int bc;
        start_i[c] = 1'b1;
        a_in[c]    = av;
        b_in[c]    = bv;
        @(posedge clk); #1;
        start_i[c] = 1'b0;
        a_in[c]    = 16'($urandom);
        b_in[c]    = 16'($urandom);
        k  = 0;
        bc = 0;
        while (!done_o[c] && k < 50) begin
            if (busy_o[c]) bc++;
            @(posedge clk); #1;
            k++;
        end
        p = prod_o[c];
        check("latency", k, cfg_w(c));
        check("busy_cycles", bc, cfg_w(c));
        check("busy_at_done", {31'b0, busy_o[c]}, 32'd0);
        @(posedge clk); #1;
        check("done_one_cycle", {31'b0, done_o[c]}, 32'd0);
        check("product_hold", prod_o[c], p);
    endtask

    typedef struct {
        int          cfg;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [7];

    initial begin
        logic [31:0] p;
        int k;
        int dcnt;
        logic [31:0] pcap;

        vecs[0] = '{0, 16'd3, 16'd3, 32'h9};
        vecs[1] = '{0, 16'd2, 16'd3, 32'h6};
        vecs[2] = '{1, 16'd15, 16'd15, 32'hE1};
        vecs[3] = '{1, 16'd0, 16'd9, 32'h0};
        vecs[4] = '{2, 16'h8, 16'h7, 32'hC8};
        vecs[5] = '{2, 16'h8, 16'h8, 32'h40};
        vecs[6] = '{2, 16'hF, 16'h1, 32'hFF};

        for (int i = 0; i < 3; i++) begin
            start_i[i] = 1'b0;
            a_in[i]    = '0;
            b_in[i]    = '0;
        end

        #2;
        for (int i = 0; i < 3; i++) begin
            check("reset_busy", {31'b0, busy_o[i]}, 32'd0);
            check("reset_done", {31'b0, done_o[i]}, 32'd0);
            check("reset_product", prod_o[i], 32'd0);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].cfg, vecs[i].a, vecs[i].b, p);
            check("table_product", p, vecs[i].exp);
        end

        for (int i = 0; i < 16; i++) begin
            run_op(0, 16'(i / 4), 16'(i % 4), p);
            check("w2_exhaustive", p, model(0, 16'(i / 4), 16'(i % 4)));
        end

        for (int i = 0; i < 40; i++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            int c;
            c  = 1 + (i % 2);
            ra = 16'($urandom_range(0, 15));
            rb = 16'($urandom_range(0, 15));
            run_op(c, ra, rb, p);
            check("random_product", p, model(c, ra, rb));
        end

        // A start raised during RUN must be ignored.
        start_i[1] = 1'b1; a_in[1] = 16'd5; b_in[1] = 16'd3;
        @(posedge clk); #1;
        start_i[1] = 1'b0;
        @(posedge clk); #1;
        start_i[1] = 1'b1; a_in[1] = 16'd2; b_in[1] = 16'd2;
        @(posedge clk); #1;
        start_i[1] = 1'b0;
        dcnt = 0;
        pcap = '0;
        for (int i = 0; i < 12; i++) begin
            if (done_o[1]) begin
                dcnt++;
                pcap = prod_o[1];
            end
            @(posedge clk); #1;
        end
        check("ignored_start_done_count", dcnt, 32'd1);
        check("ignored_start_product", pcap, 32'd15);
        check("ignored_start_idle", {31'b0, busy_o[1]}, 32'd0);

        // Back-to-back: second start accepted in the DONE cycle.
        start_i[1] = 1'b1; a_in[1] = 16'd6; b_in[1] = 16'd7;
        @(posedge clk); #1;
        k = 0;
        while (!done_o[1] && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check("b2b_first_product", prod_o[1], 32'd42);
        a_in[1] = 16'd4; b_in[1] = 16'd4;
        @(posedge clk); #1;
        start_i[1] = 1'b0;
        k = 1;
        while (!done_o[1] && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check("b2b_spacing", k, 32'd5);
        check("b2b_second_product", prod_o[1], 32'd16);
        @(posedge clk); #1;

        // Asynchronous reset two cycles into RUN.
        start_i[1] = 1'b1; a_in[1] = 16'd5; b_in[1] = 16'd3;
        @(posedge clk); #1;
        start_i[1] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_reset_busy", {31'b0, busy_o[1]}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_busy", {31'b0, busy_o[1]}, 32'd0);
        check("async_reset_done", {31'b0, done_o[1]}, 32'd0);
        check("async_reset_product", prod_o[1], 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(1, 16'd9, 16'd9, p);
        check("post_reset_product", p, 32'd81);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
